// File: rtl/irq_priority_dispatcher_if.sv
// ----------------------------------------------------------------------------
// irq_priority_dispatcher_if
// Purpose : system-bus bundle used to reach the interrupt dispatcher's
//           control/status registers.
// Signals :
//   bus_valid  master -> slave  access strobe
//   bus_write  master -> slave  1 = write, 0 = read
//   bus_addr   master -> slave  byte address, register select on [3:2]
//   bus_wdata  master -> slave  write data
//   bus_rdata  slave  -> master read data, combinational, 0 unless reading
// ----------------------------------------------------------------------------
interface irq_priority_dispatcher_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 19
);
  logic              bus_valid;
  logic              bus_write;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  // The CPU-side bus bridge drives the access.
  modport master (
    output bus_valid,
    output bus_write,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata
  );

  // The dispatcher decodes the access and returns read data.
  modport slave (
    input  bus_valid,
    input  bus_write,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/irq_priority_dispatcher.sv
// ----------------------------------------------------------------------------
// irq_priority_dispatcher
// Purpose : vectored, priority-arbitrated interrupt dispatcher between the
//           FFT (0), crypto (1) and timer (2) IRQ sources and the CPU core.
//           Rising edges are latched as pending bits, masked by a software
//           enable register, and one vector at a time is presented to the
//           CPU and walked through ack and end-of-interrupt.
// Ports   :
//   clk            system clock
//   rst_n          asynchronous, active-low reset
//   bus            register bus (slave modport), registers on bus_addr[3:2]:
//                    00 PENDING RO, 01 ENABLE RW, 10 CLEAR W1C, 11 STATUS RO
//   irq_src_i      interrupt sources, rising-edge sensitive
//   cpu_irq_o      registered interrupt request to the CPU
//   cpu_irq_vec_o  registered vector of the presented source
//   cpu_irq_ack_i  one-cycle pulse, CPU takes the presented interrupt
//   cpu_eoi_i      one-cycle pulse, CPU finished the service routine
// ----------------------------------------------------------------------------
module irq_priority_dispatcher #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 19,
  parameter int ADDR_W  = 19,
  parameter int VEC_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  irq_priority_dispatcher_if.slave bus,
  input  logic [NUM_SRC-1:0]   irq_src_i,
  output logic                 cpu_irq_o,
  output logic [VEC_W-1:0]     cpu_irq_vec_o,
  input  logic                 cpu_irq_ack_i,
  input  logic                 cpu_eoi_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } state_e;

  localparam logic [1:0] SEL_PENDING = 2'b00;
  localparam logic [1:0] SEL_ENABLE  = 2'b01;
  localparam logic [1:0] SEL_CLEAR   = 2'b10;
  localparam logic [1:0] SEL_STATUS  = 2'b11;

  state_e             state_q;
  logic               cpu_irq_q;
  logic [VEC_W-1:0]   cpu_irq_vec_q;
  logic               in_service_q;

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] clr_mask;
  logic [NUM_SRC-1:0] ack_mask;
  logic [NUM_SRC-1:0] active_now;
  logic [NUM_SRC-1:0] active_next;

  logic               wr_en;
  logic [1:0]         reg_sel;
  logic               ack_take;
  logic               arb_hit;
  logic [VEC_W-1:0]   arb_vec;
  logic               unused_bits;

  assign reg_sel  = bus.bus_addr[3:2];
  assign wr_en    = bus.bus_valid & bus.bus_write;
  assign ack_take = (state_q == PEND) && cpu_irq_ack_i;

  // src_q resets to 0, so a source held high across reset release looks
  // like exactly one rising edge on the first clock afterwards.
  assign src_rise = irq_src_i & ~src_q;

  // Only bus_addr[3:2] and the low NUM_SRC write-data bits carry meaning.
  assign unused_bits = ^{bus.bus_addr[ADDR_W-1:4], bus.bus_addr[1:0],
                         bus.bus_wdata[DATA_W-1:NUM_SRC]};

  // Next-state of the pending and enable registers. The edge term is OR-ed
  // in last so a fresh edge beats both a CLEAR write and an ack clear on the
  // same bit; that is what lets the in-service source re-issue after EOI.
  always_comb begin
    clr_mask = '0;
    if (wr_en && reg_sel == SEL_CLEAR) begin
      clr_mask = bus.bus_wdata[NUM_SRC-1:0];
    end
    ack_mask = '0;
    if (ack_take) begin
      ack_mask[cpu_irq_vec_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr_mask & ~ack_mask) | src_rise;
    enable_d  = enable_q;
    if (wr_en && reg_sel == SEL_ENABLE) begin
      enable_d = bus.bus_wdata[NUM_SRC-1:0];
    end
  end

  assign active_now  = pending_q & enable_q;
  assign active_next = pending_d & enable_d;

  // Fixed-priority pick: scanning from the top down leaves the lowest set
  // index, which is the highest priority source.
  always_comb begin
    arb_hit = 1'b0;
    arb_vec = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active_now[i]) begin
        arb_hit = 1'b1;
        arb_vec = VEC_W'(i);
      end
    end
  end

  // Source history, pending and enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
    end else begin
      src_q     <= irq_src_i;
      pending_q <= pending_d;
      enable_q  <= enable_d;
    end
  end

  // Dispatch FSM with registered CPU-facing outputs. While presenting, the
  // withdraw test looks at the pending/enable values being written this
  // cycle, so a CLEAR or disable drops cpu_irq on the very next clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cpu_irq_q     <= 1'b0;
      cpu_irq_vec_q <= '0;
      in_service_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arb_hit) begin
            cpu_irq_vec_q <= arb_vec;
            cpu_irq_q     <= 1'b1;
            state_q       <= PEND;
          end
        end
        PEND: begin
          if (cpu_irq_ack_i) begin
            in_service_q <= 1'b1;
            cpu_irq_q    <= 1'b0;
            state_q      <= SERV;
          end else if (!active_next[cpu_irq_vec_q]) begin
            cpu_irq_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        SERV: begin
          if (cpu_eoi_i) begin
            in_service_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          cpu_irq_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // Combinational register read-back; idle bus reads as zero.
  always_comb begin
    bus.bus_rdata = '0;
    if (bus.bus_valid && !bus.bus_write) begin
      unique case (reg_sel)
        SEL_PENDING: bus.bus_rdata = DATA_W'(pending_q);
        SEL_ENABLE:  bus.bus_rdata = DATA_W'(enable_q);
        SEL_CLEAR:   bus.bus_rdata = '0;
        SEL_STATUS:  bus.bus_rdata = DATA_W'({in_service_q, cpu_irq_vec_q, state_q});
        default:     bus.bus_rdata = '0;
      endcase
    end
  end

  assign cpu_irq_o     = cpu_irq_q;
  assign cpu_irq_vec_o = cpu_irq_vec_q;

endmodule

// File: tb/tb_irq_priority_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_irq_priority_dispatcher
// Purpose : directed scenarios with literal expectations followed by a
//           randomized run, all checked against a cycle-level behavioural
//           model of the dispatcher held inside this bench.
// ----------------------------------------------------------------------------
module tb_irq_priority_dispatcher;

  localparam int NUM_SRC = 3;
  localparam int DATA_W  = 19;
  localparam int ADDR_W  = 19;
  localparam int VEC_W   = 2;

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_PEND = 2'd1;
  localparam logic [1:0] M_SERV = 2'd2;

  logic             clk;
  logic             rst_n;
  logic [2:0]       irqSrc;
  logic             ack;
  logic             eoi;
  logic             cpuIrq;
  logic [VEC_W-1:0] cpuVec;
  logic [DATA_W-1:0] rd;
  bit               checkEn;

  int vecCount  = 0;
  int missCount = 0;

  irq_priority_dispatcher_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) busIf ();

  irq_priority_dispatcher #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .VEC_W(VEC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (busIf),
    .irq_src_i    (irqSrc),
    .cpu_irq_o    (cpuIrq),
    .cpu_irq_vec_o(cpuVec),
    .cpu_irq_ack_i(ack),
    .cpu_eoi_i    (eoi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural state of the dispatcher as the rules describe it.
  typedef struct packed {
    logic [2:0] pend;
    logic [2:0] en;
    logic [2:0] srcPrev;
    logic [1:0] st;
    logic       irq;
    logic [1:0] vec;
    logic       insvc;
  } model_t;

  model_t m;

  // One clock of the dispatcher rules applied to the model state.
  function automatic model_t modelStep(model_t s, logic [2:0] src, logic v,
                                       logic w, logic [1:0] sel,
                                       logic [2:0] wd, logic a, logic e);
    model_t n = s;
    logic [2:0] rise = src & ~s.srcPrev;
    logic [2:0] clr = (v && w && sel == 2'd2) ? wd : 3'b000;
    logic ackTaken = (s.st == M_PEND) && a;
    logic [2:0] want;
    n.srcPrev = src;
    if (v && w && sel == 2'd1) n.en = wd;
    n.pend = s.pend & ~clr;
    if (ackTaken) n.pend[s.vec] = 1'b0;
    n.pend = n.pend | rise;
    case (s.st)
      M_IDLE: begin
        want = s.pend & s.en;
        if (want != 3'b000) begin
          for (int i = 2; i >= 0; i--) if (want[i]) n.vec = 2'(i);
          n.irq = 1'b1;
          n.st  = M_PEND;
        end
      end
      M_PEND: begin
        want = n.pend & n.en;
        if (ackTaken) begin
          n.insvc = 1'b1;
          n.irq   = 1'b0;
          n.st    = M_SERV;
        end else if (!want[s.vec]) begin
          n.irq = 1'b0;
          n.st  = M_IDLE;
        end
      end
      default: begin
        if (e) begin
          n.insvc = 1'b0;
          n.st    = M_IDLE;
        end
      end
    endcase
    return n;
  endfunction

  // Value the bus must return for the model state and the current access.
  function automatic logic [DATA_W-1:0] expRead(model_t s, logic v, logic w,
                                                logic [1:0] sel);
    if (!(v && !w)) return '0;
    case (sel)
      2'd0:    return DATA_W'(s.pend);
      2'd1:    return DATA_W'(s.en);
      2'd2:    return '0;
      default: return DATA_W'({s.insvc, s.vec, s.st});
    endcase
  endfunction

  // Advance the model alongside the DUT, including asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= modelStep(m, irqSrc, busIf.bus_valid, busIf.bus_write,
                        busIf.bus_addr[3:2], busIf.bus_wdata[2:0], ack, eoi);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Compare the DUT against the model mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model cpu_irq", 32'(cpuIrq), 32'(m.irq));
      checkOutput("model cpu_irq_vec", 32'(cpuVec), 32'(m.vec));
      checkOutput("model bus_rdata", 32'(busIf.bus_rdata),
                  32'(expRead(m, busIf.bus_valid, busIf.bus_write,
                              busIf.bus_addr[3:2])));
    end
  end

  // Hold one set of inputs across a rising edge, then drop the pulses.
  task automatic applyStimulus(input logic [2:0] src, input logic v,
                               input logic w, input logic [1:0] sel,
                               input logic [DATA_W-1:0] wd, input logic a,
                               input logic e);
    irqSrc           = src;
    busIf.bus_valid  = v;
    busIf.bus_write  = w;
    busIf.bus_addr   = ADDR_W'({sel, 2'b00});
    busIf.bus_wdata  = wd;
    ack              = a;
    eoi              = e;
    @(posedge clk);
    #1;
    busIf.bus_valid = 1'b0;
    busIf.bus_write = 1'b0;
    ack             = 1'b0;
    eoi             = 1'b0;
  endtask

  task automatic idleCycle(input logic [2:0] src);
    applyStimulus(src, 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
  endtask

  task automatic writeReg(input logic [1:0] sel, input logic [2:0] val,
                          input logic [2:0] src);
    applyStimulus(src, 1'b1, 1'b1, sel, DATA_W'(val), 1'b0, 1'b0);
  endtask

  // Reads have no side effects, so they are done between clock edges.
  task automatic readReg(input logic [1:0] sel, output logic [DATA_W-1:0] d);
    busIf.bus_valid = 1'b1;
    busIf.bus_write = 1'b0;
    busIf.bus_addr  = ADDR_W'({sel, 2'b00});
    #1;
    d = busIf.bus_rdata;
    busIf.bus_valid = 1'b0;
  endtask

  task automatic checkReg(input string name, input logic [1:0] sel,
                          input logic [31:0] expected);
    logic [DATA_W-1:0] d;
    readReg(sel, d);
    checkOutput(name, 32'(d), expected);
  endtask

  initial begin
    rst_n = 1'b0;
    irqSrc = '0;
    ack = 1'b0;
    eoi = 1'b0;
    checkEn = 1'b0;
    busIf.bus_valid = 1'b0;
    busIf.bus_write = 1'b0;
    busIf.bus_addr  = '0;
    busIf.bus_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkEn = 1'b1;

    // Reset state.
    checkReg("reset PENDING", 2'd0, 0);
    checkReg("reset ENABLE", 2'd1, 0);
    checkReg("reset STATUS", 2'd3, 0);
    checkOutput("reset cpu_irq", 32'(cpuIrq), 0);

    // Single source: pending after one cycle, request after two.
    writeReg(2'd1, 3'b111, 3'b000);
    idleCycle(3'b010);
    checkReg("s1 PENDING", 2'd0, 32'b010);
    checkOutput("s1 cpu_irq early", 32'(cpuIrq), 0);
    idleCycle(3'b000);
    checkOutput("s1 cpu_irq", 32'(cpuIrq), 1);
    checkOutput("s1 vec", 32'(cpuVec), 1);
    checkOutput("s1 model irq", 32'(m.irq), 1);
    checkOutput("s1 model vec", 32'(m.vec), 1);
    checkReg("s1 STATUS PEND", 2'd3, 32'b00101);
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    checkOutput("s1 cpu_irq after ack", 32'(cpuIrq), 0);
    checkReg("s1 PENDING after ack", 2'd0, 0);
    checkReg("s1 STATUS SERV", 2'd3, 32'b10110);
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1);
    checkReg("s1 STATUS after eoi", 2'd3, 32'b00100);

    // Two simultaneous sources: lower index first, the other after EOI.
    idleCycle(3'b110);
    checkReg("s2 PENDING", 2'd0, 32'b110);
    idleCycle(3'b000);
    checkOutput("s2 first vec", 32'(cpuVec), 1);
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1);
    checkOutput("s2 cpu_irq at idle", 32'(cpuIrq), 0);
    idleCycle(3'b000);
    checkOutput("s2 second cpu_irq", 32'(cpuIrq), 1);
    checkOutput("s2 second vec", 32'(cpuVec), 2);

    // Withdraw by CLEAR, then CLEAR and ack together.
    writeReg(2'd2, 3'b100, 3'b000);
    checkOutput("s4 cpu_irq withdrawn", 32'(cpuIrq), 0);
    checkReg("s4 STATUS idle", 2'd3, 32'b01000);
    checkReg("s4 PENDING", 2'd0, 0);
    idleCycle(3'b100);
    idleCycle(3'b000);
    checkOutput("s4 re-present vec", 32'(cpuVec), 2);
    applyStimulus(3'b000, 1'b1, 1'b1, 2'd2, DATA_W'(3'b100), 1'b1, 1'b0);
    checkReg("s4 ack beats clear", 2'd3, 32'b11010);
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1);

    // Pending while disabled, released by an ENABLE write.
    writeReg(2'd1, 3'b000, 3'b000);
    idleCycle(3'b001);
    checkReg("s3 PENDING", 2'd0, 32'b001);
    idleCycle(3'b000);
    idleCycle(3'b000);
    checkOutput("s3 masked cpu_irq", 32'(cpuIrq), 0);
    writeReg(2'd1, 3'b001, 3'b000);
    checkOutput("s3 cpu_irq one cycle", 32'(cpuIrq), 0);
    idleCycle(3'b000);
    checkOutput("s3 cpu_irq", 32'(cpuIrq), 1);
    checkOutput("s3 vec", 32'(cpuVec), 0);

    // Same source re-fires during service and re-issues after EOI.
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    checkReg("s5 STATUS SERV", 2'd3, 32'b10010);
    idleCycle(3'b001);
    checkReg("s5 PENDING", 2'd0, 32'b001);
    idleCycle(3'b000);
    idleCycle(3'b000);
    checkOutput("s5 no nesting", 32'(cpuIrq), 0);
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1);
    checkOutput("s5 cpu_irq after eoi", 32'(cpuIrq), 0);
    idleCycle(3'b000);
    checkOutput("s5 re-issue", 32'(cpuIrq), 1);
    checkOutput("s5 re-issue vec", 32'(cpuVec), 0);

    // Asynchronous reset while presenting, timer held high through release.
    irqSrc = 3'b100;
    rst_n  = 1'b0;
    #1;
    checkOutput("s6 cpu_irq in reset", 32'(cpuIrq), 0);
    checkReg("s6 PENDING in reset", 2'd0, 0);
    checkReg("s6 ENABLE in reset", 2'd1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idleCycle(3'b100);
    checkReg("s6 held-high edge", 2'd0, 32'b100);
    writeReg(2'd2, 3'b100, 3'b100);
    idleCycle(3'b100);
    idleCycle(3'b100);
    checkReg("s6 no replay", 2'd0, 0);
    checkOutput("s6 cpu_irq", 32'(cpuIrq), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] src;
      logic v, w, a, e;
      logic [1:0] sel;
      src = irqSrc;
      if ($urandom_range(0, 3) == 0) src = src ^ 3'($urandom);
      v   = ($urandom_range(0, 2) == 0);
      w   = 1'($urandom);
      sel = 2'($urandom);
      a   = ($urandom_range(0, 2) == 0);
      e   = ($urandom_range(0, 3) == 0);
      irqSrc          = src;
      busIf.bus_valid = v;
      busIf.bus_write = w;
      busIf.bus_addr  = ADDR_W'($urandom);
      busIf.bus_addr[3:2] = sel;
      busIf.bus_wdata = DATA_W'($urandom);
      ack = a;
      eoi = e;
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    busIf.bus_valid = 1'b0;
    ack = 1'b0;
    eoi = 1'b0;
    @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
